// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg -- shared types and helpers for the common-data-bus arbiter.
//
// Contents:
//   cdb_entry_t        : one buffered result, {tag, val}
//   CDB_NUM_SRC_DEF    : default number of result producers
//   CDB_FIFO_DEPTH_DEF : default entries per source FIFO
//   clog2()            : ceiling log2, usable in constant expressions
//
// `INST_TAG_WIDTH, `COMMON_WIDTH and `TAG_INVALID normally come from
// common_def.h. The guarded fallbacks below only take effect when that header
// has not been included earlier in the compilation unit, so a standalone build
// of this slice still elaborates with the project's usual values.

`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 6
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef TAG_INVALID
`define TAG_INVALID {`INST_TAG_WIDTH{1'b1}}
`endif

package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC_DEF    = 4;
  localparam int CDB_FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic [`INST_TAG_WIDTH-1:0] tag;
    logic [`COMMON_WIDTH-1:0]   val;
  } cdb_entry_t;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo -- per-source result buffer feeding the CDB arbiter.
//
// A DEPTH-entry circular FIFO of {tag, val}. The head is read combinationally
// so the arbiter can forward it in the same cycle it decides to pop.
//
// Ports:
//   clk        : clock, all updates on posedge
//   rst        : asynchronous active-high reset (clears pointers and count)
//   push       : enqueue push_data this edge (ignored when full and not popped)
//   push_data  : entry to enqueue
//   pop        : dequeue the head this edge
//   head       : current oldest entry (valid while count != 0)
//   count      : number of stored entries, clog2(DEPTH)+1 bits
//   full       : count == DEPTH

module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cdb_entry_t             push_data,
  input  logic                   pop,
  output cdb_entry_t             head,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  cdb_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign head  = mem[rd_ptr];

  // A full FIFO still accepts a push when its head leaves on the same edge:
  // the write lands in the slot the pop is vacating.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; stale data is unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- merges result streams from NUM_SRC producers onto the single
// ROB writeback port (common data bus).
//
// Each source owns a cdb_src_fifo. Every cycle at most one non-empty FIFO is
// granted (judged on pre-edge counts) and its head is registered onto
// wb_tag/wb_val. Pushes into a full FIFO that is not popped are dropped and
// latch the sticky overflow flag.
//
// Build option:
//   CDB_ARB_ROUND_ROBIN_EN defined   : round-robin grant, pointer moves to
//                                      (granted + 1) mod NUM_SRC on each grant
//   CDB_ARB_ROUND_ROBIN_EN undefined : fixed priority, lowest index wins
//
// Ports:
//   clk, rst     : clock / asynchronous active-high reset
//   src_target   : per-source ROB tag, `TAG_INVALID = nothing this cycle
//   src_result   : per-source result value
//   src_stall    : per-source almost-full (count >= FIFO_DEPTH-1), combinational
//   wb_tag       : ROB entry written this cycle, `TAG_INVALID = idle
//   wb_val       : value written (holds its last value while idle)
//   overflow     : sticky, a result was dropped

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC_DEF,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC-1:0][`INST_TAG_WIDTH-1:0] src_target,
  input  logic [NUM_SRC-1:0][`COMMON_WIDTH-1:0]   src_result,
  output logic [NUM_SRC-1:0]                      src_stall,
  output logic [`INST_TAG_WIDTH-1:0]              wb_tag,
  output logic [`COMMON_WIDTH-1:0]                wb_val,
  output logic                                    overflow
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam int GW = (NUM_SRC > 1) ? clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] drop;
  cdb_entry_t         head  [NUM_SRC];
  logic [CW-1:0]      count [NUM_SRC];

  logic               grant_valid;
  logic [GW-1:0]      grant_idx;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      cdb_entry_t push_data;

      assign push_data     = '{tag: src_target[gi], val: src_result[gi]};
      assign push[gi]      = (src_target[gi] != `TAG_INVALID);
      assign nonempty[gi]  = (count[gi] != '0);
      assign src_stall[gi] = (count[gi] >= CW'(FIFO_DEPTH - 1));
      assign drop[gi]      = push[gi] && full[gi] && !pop[gi];

      cdb_src_fifo #(
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push[gi]),
        .push_data (push_data),
        .pop       (pop[gi]),
        .head      (head[gi]),
        .count     (count[gi]),
        .full      (full[gi])
      );
    end
  endgenerate

`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr;

  // Scan sources starting at rr_ptr; the first non-empty one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_valid && nonempty[(int'(rr_ptr) + k) % NUM_SRC]) begin
        grant_valid = 1'b1;
        grant_idx   = GW'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  // Pointer only advances on a grant, so idle cycles keep the fairness order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_valid && nonempty[k]) begin
        grant_valid = 1'b1;
        grant_idx   = GW'(k);
      end
    end
  end
`endif

  always_comb begin
    pop = '0;
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_tag   <= `TAG_INVALID;
      wb_val   <= '0;
      overflow <= 1'b0;
    end else begin
      if (grant_valid) begin
        wb_tag <= head[grant_idx].tag;
        wb_val <= head[grant_idx].val;
      end else begin
        wb_tag <= `TAG_INVALID;
      end
      if (|drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of result producers (forwarder, ALU, LSU, branch unit).
REQ-002 Parameter FIFO_DEPTH, default 4, entries per source FIFO, power of two and at least 2.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 src_target  input  NUM_SRC x `INST_TAG_WIDTH  ROB tag of each produced result; `TAG_INVALID = no result this cycle.
REQ-006 src_result  input  NUM_SRC x `COMMON_WIDTH  result value per source.
REQ-007 src_stall  output  NUM_SRC  per-source almost-full; upstream holds off new results while high.
REQ-008 wb_tag  output  `INST_TAG_WIDTH  ROB entry being written; `TAG_INVALID = idle.
REQ-009 wb_val  output  `COMMON_WIDTH  value written to ROB entry wb_tag.
REQ-010 overflow  output  1  sticky error: a result was dropped.

Function
REQ-011 Each source SHALL own one FIFO of FIFO_DEPTH {tag, val} entries with wrap-around read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
REQ-012 Push: at posedge, src_target[i] != `TAG_INVALID SHALL enqueue {src_target[i], src_result[i]} into FIFO i.
REQ-013 Pop: at the same posedge the arbiter SHALL select at most one non-empty FIFO, evaluated on pre-edge counts, dequeue its head, and register it onto wb_tag/wb_val.
REQ-014 With no FIFO non-empty before the edge, wb_tag SHALL become `TAG_INVALID and wb_val SHALL hold its previous value.
REQ-015 Latency: a result pushed into an empty FIFO at edge N with no competitors SHALL appear on wb_tag/wb_val after edge N+1 and stay valid exactly one cycle.
REQ-016 Throughput: one writeback per cycle; no bubble while any FIFO is non-empty.
REQ-017 Simultaneous push and pop on the same FIFO SHALL both take effect, leaving the count unchanged; this holds even when the FIFO is full.
REQ-018 Push into a full FIFO not popped that edge SHALL be dropped, leave the FIFO unchanged, and set overflow, which stays high until reset.
REQ-019 src_stall[i] SHALL be combinational: high when count[i] >= FIFO_DEPTH-1.
REQ-020 Results from one source SHALL be written back in arrival order; no ordering is guaranteed between sources.
REQ-021 No tag comparison or merging is performed; duplicate tags pass through unchanged.

Reset
REQ-022 rst high SHALL immediately clear all FIFO pointers and counts, set wb_tag=`TAG_INVALID, wb_val=0 and overflow=0, and drop all in-flight entries, including when asserted mid-burst.
REQ-023 While rst is high, no push or pop SHALL occur; the first push is sampled at the first posedge after deassertion.

Configuration
REQ-024 Macro CDB_ARB_ROUND_ROBIN_EN defined: round-robin grant with a pointer set to (granted index + 1) mod NUM_SRC after each grant, starting at 0 after reset; the pointer does not move on idle cycles.
REQ-025 Macro undefined: fixed priority, lowest source index wins; no pointer register exists.

Structure
REQ-026 The shared package SHALL hold the cdb_entry struct {tag, val}, NUM_SRC/FIFO_DEPTH defaults and the clog2 helper; `TAG_INVALID, `INST_TAG_WIDTH and `COMMON_WIDTH come from common_def.h.
REQ-027 Per-source buffering SHALL be one sub-module, cdb_src_fifo (push, pop, head, count, full), instantiated NUM_SRC times; arbitration stays in cdb_arbiter.

Verification
REQ-028 Single source 1 pushes tag 5 / val 0xAB at edge 0 -> wb_tag=5, wb_val=0xAB after edge 1; wb_tag=`TAG_INVALID after edge 2.
REQ-029 All 4 sources push tags 1..4 in the same cycle, RR build -> writebacks ordered 1,2,3,4 over 4 consecutive cycles; fixed build gives the same order; a repeat burst in the RR build starts at source 0 since the pointer wrapped.
REQ-030 Source 0 pushes every cycle (tags 10..17) while source 2 pushes tag 30 once -> RR build writes tag 30 within 2 cycles; fixed build writes 30 only after source 0 drains.
REQ-031 Source 3 pushes 6 results back-to-back with another source hogging the grant (fixed build) -> src_stall[3] high at count 3, 5th push dropped, overflow=1; the 4 retained results come out in order.
REQ-032 Full FIFO with simultaneous push and pop -> count stays 4, no overflow, order preserved.
REQ-033 rst pulsed asynchronously mid-burst with 3 entries queued -> wb_tag=`TAG_INVALID immediately; no stale entry is written after release.
